ard_cmd_scheduler: RTL and testbench

Sequences commands to the Arduino arm controller over the 5-bit GPIO command bus. It is shared between the automatic vision/search FSM and the manual switch panel. Each granted command is emitted as a timed frame: SETUP with the command lines stable, then STROBE with the implement bit high, then GUARD. An emergency abort preempts any frame with STOP. The block sits between the requesters and the GPIO pins and replaces ad-hoc per-requester timing.

---
 rtl/ard_cmd_scheduler_pkg.sv | 33 +++
 rtl/ard_cmd_scheduler_if.sv | 27 ++
 rtl/ard_cmd_scheduler_phase_timer.sv | 26 ++
 rtl/ard_cmd_scheduler.sv | 129 ++++++++++++
 tb/tb_ard_cmd_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ard_cmd_scheduler_pkg.sv
// Command encodings, FSM states and the command-to-pin mapping shared by the
// Arduino command scheduler, its requester interface and the testbench.
package ard_cmd_pkg;

   typedef enum logic [1:0] {
      CMD_RESET_POS = 2'd0,
      CMD_SEARCH    = 2'd1,
      CMD_PLACE     = 2'd2,
      CMD_STOP      = 2'd3
   } cmd_t;

   localparam logic [3:0] CMD_OH_RESET_POS = 4'b0010;
   localparam logic [3:0] CMD_OH_SEARCH    = 4'b1000;
   localparam logic [3:0] CMD_OH_PLACE     = 4'b0100;
   localparam logic [3:0] CMD_OH_STOP      = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_GUARD
   } state_t;

   function automatic logic [3:0] cmd_to_onehot(input cmd_t cmd);
      case (cmd)
         CMD_RESET_POS: cmd_to_onehot = CMD_OH_RESET_POS;
         CMD_SEARCH:    cmd_to_onehot = CMD_OH_SEARCH;
         CMD_PLACE:     cmd_to_onehot = CMD_OH_PLACE;
         default:       cmd_to_onehot = CMD_OH_STOP;
      endcase
   endfunction

endpackage

// File: rtl/ard_cmd_scheduler_if.sv
// Requester-side bundle: two command requesters plus the emergency abort line.
interface ard_cmd_scheduler_if;
   import ard_cmd_pkg::*;

   logic [1:0] req_valid;
   cmd_t       req_cmd0;
   cmd_t       req_cmd1;
   logic [1:0] req_ready;
   logic       abort_stop;

   modport master (
      output req_valid,
      output req_cmd0,
      output req_cmd1,
      output abort_stop,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_cmd0,
      input  req_cmd1,
      input  abort_stop,
      output req_ready
   );

endinterface

// File: rtl/ard_cmd_scheduler_phase_timer.sv
// Loadable down-counter that times one frame phase; it parks at zero.
module ard_phase_timer #(
   parameter int CNT_W = 27
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/ard_cmd_scheduler.sv
// Arbitrates the auto FSM and manual panel onto the Arduino GPIO command bus
// and emits each command as a SETUP / STROBE / GUARD frame, with STOP preemption.
module ard_cmd_scheduler
   import ard_cmd_pkg::*;
#(
   parameter int SETUP_CYCLES  = 25_000_000,
   parameter int STROBE_CYCLES = 25_000_000,
   parameter int GUARD_CYCLES  = 1_000_000,
   parameter int CNT_W         = 27
) (
   input  logic                i_clock_50,
   input  logic                i_resetn,
   ard_cmd_scheduler_if.slave  bus,
   output logic [4:0]          o_sig_out,
   output logic                o_busy,
   output logic                o_done
);

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);

   state_t           r_state, w_state_nxt;
   cmd_t             r_cmd, w_cmd_nxt;
   logic             r_last_grant, w_last_grant_nxt;
   logic [1:0]       w_grant;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_zero;
   logic             w_done_nxt;
   logic [4:0]       r_sig_out;
   logic             r_busy;
   logic             r_done;

   ard_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
      .i_clk      (i_clock_50),
      .i_rst_n    (i_resetn),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   // r_last_grant=1 means port 1 won last, so port 0 wins the next tie.
   always_comb begin
      w_grant = 2'b00;
      if (r_state == ST_IDLE && !bus.abort_stop) begin
         if (bus.req_valid == 2'b11) begin
            w_grant = r_last_grant ? 2'b01 : 2'b10;
         end else begin
            w_grant = bus.req_valid;
         end
      end
   end

   assign bus.req_ready = w_grant;

   always_comb begin
      w_state_nxt      = r_state;
      w_cmd_nxt        = r_cmd;
      w_last_grant_nxt = r_last_grant;
      w_load           = 1'b0;
      w_load_val       = '0;
      w_done_nxt       = 1'b0;

      if (bus.abort_stop && (r_state == ST_IDLE || r_cmd != CMD_STOP)) begin
         w_state_nxt = ST_SETUP;
         w_cmd_nxt   = CMD_STOP;
         w_load      = 1'b1;
         w_load_val  = SETUP_LOAD;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant != 2'b00) begin
                  w_state_nxt      = ST_SETUP;
                  w_cmd_nxt        = w_grant[0] ? bus.req_cmd0 : bus.req_cmd1;
                  w_last_grant_nxt = w_grant[1];
                  w_load           = 1'b1;
                  w_load_val       = SETUP_LOAD;
               end
            end
            ST_SETUP: begin
               if (w_zero) begin
                  w_state_nxt = ST_STROBE;
                  w_load      = 1'b1;
                  w_load_val  = STROBE_LOAD;
               end
            end
            ST_STROBE: begin
               if (w_zero) begin
                  w_state_nxt = ST_GUARD;
                  w_load      = 1'b1;
                  w_load_val  = GUARD_LOAD;
               end
            end
            ST_GUARD: begin
               if (w_zero) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs are registered from next-state so pins change exactly at phase edges.
   always_ff @(posedge i_clock_50 or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state      <= ST_IDLE;
         r_cmd        <= CMD_RESET_POS;
         r_last_grant <= 1'b1;
         r_sig_out    <= {CMD_OH_RESET_POS, 1'b0};
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cmd        <= w_cmd_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_sig_out    <= {cmd_to_onehot(w_cmd_nxt), (w_state_nxt == ST_STROBE)};
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_done       <= w_done_nxt;
      end
   end

   assign o_sig_out = r_sig_out;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_ard_cmd_scheduler.sv
// Self-checking bench for ard_cmd_scheduler: directed scenarios plus a randomized
// run compared against a frame-age reference model.
`timescale 1ns/1ps
module tb_ard_cmd_scheduler;
   import ard_cmd_pkg::*;

   localparam int SETUP  = 4;
   localparam int STROBE = 3;
   localparam int GUARD  = 2;
   localparam int FRAME  = SETUP + STROBE + GUARD + 1;

   logic       clock50 = 1'b0;
   logic       resetn  = 1'b1;
   logic [4:0] sigOut;
   logic       busy;
   logic       done;
   int         errors  = 0;
   int         checks  = 0;

   ard_cmd_scheduler_if bus();

   ard_cmd_scheduler #(
      .SETUP_CYCLES  (SETUP),
      .STROBE_CYCLES (STROBE),
      .GUARD_CYCLES  (GUARD),
      .CNT_W         (8)
   ) dut (
      .i_clock_50 (clock50),
      .i_resetn   (resetn),
      .bus        (bus),
      .o_sig_out  (sigOut),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clock50 = ~clock50;

   // Reference model: a frame is tracked only by its command and its age in
   // cycles since the grant edge; age FRAME is the done/idle cycle.
   bit         mActive = 1'b0;
   int         mAge    = 0;
   cmd_t       mCmd    = CMD_RESET_POS;
   bit         mLast   = 1'b1;
   logic [1:0] mGrant;

   function automatic logic [3:0] ohRef(input cmd_t c);
      logic [3:0] table4 [4];
      table4[0] = 4'b0010;
      table4[1] = 4'b1000;
      table4[2] = 4'b0100;
      table4[3] = 4'b0001;
      return table4[int'(c)];
   endfunction

   function automatic bit mIdle();
      return !mActive || mAge >= FRAME;
   endfunction

   function automatic logic [4:0] expSig();
      logic strobe;
      strobe = mActive && (mAge > SETUP) && (mAge <= SETUP + STROBE);
      return {ohRef(mCmd), strobe};
   endfunction

   function automatic logic expBusy();
      return mActive && mAge < FRAME;
   endfunction

   function automatic logic expDone();
      return mActive && mAge == FRAME;
   endfunction

   function automatic logic [1:0] expReady();
      if (!mIdle() || bus.abort_stop) return 2'b00;
      if (bus.req_valid == 2'b11) return mLast ? 2'b01 : 2'b10;
      return bus.req_valid;
   endfunction

   always @(posedge clock50 or negedge resetn) begin
      if (!resetn) begin
         mActive = 1'b0;
         mAge    = 0;
         mCmd    = CMD_RESET_POS;
         mLast   = 1'b1;
      end else begin
         mGrant = expReady();
         if (mIdle()) begin
            if (bus.abort_stop) begin
               mCmd = CMD_STOP; mActive = 1'b1; mAge = 1;
            end else if (mGrant[0]) begin
               mCmd = bus.req_cmd0; mLast = 1'b0; mActive = 1'b1; mAge = 1;
            end else if (mGrant[1]) begin
               mCmd = bus.req_cmd1; mLast = 1'b1; mActive = 1'b1; mAge = 1;
            end else begin
               mActive = 1'b0; mAge = 0;
            end
         end else if (bus.abort_stop && mCmd != CMD_STOP) begin
            mCmd = CMD_STOP; mAge = 1;
         end else begin
            mAge++;
         end
      end
   end

   task automatic pulseReset();
      @(posedge clock50); #1;
      bus.req_valid  = 2'b00;
      bus.abort_stop = 1'b0;
      resetn = 1'b0;
      #1 resetn = 1'b1;
   endtask

   task automatic test_reset();
      bus.req_valid  = 2'b00;
      bus.req_cmd0   = CMD_RESET_POS;
      bus.req_cmd1   = CMD_RESET_POS;
      bus.abort_stop = 1'b0;
      #2 resetn = 1'b0;
      repeat (2) @(negedge clock50);
      checks++; if (sigOut !== 5'b00100) begin errors++; $display("[TB] FAIL reset_sig: got %b want 00100", sigOut); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", bus.req_ready); end
      @(posedge clock50); #1 resetn = 1'b1;
      repeat (3) begin
         @(negedge clock50);
         checks++; if (sigOut !== 5'b00100) begin errors++; $display("[TB] FAIL release_sig: got %b want 00100", sigOut); end
         checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL release_flags: got busy=%b done=%b want 0/0", busy, done); end
      end
   endtask

   task automatic test_single_command();
      logic [4:0] want;
      pulseReset();
      bus.req_cmd0  = CMD_SEARCH;
      bus.req_valid = 2'b01;
      @(negedge clock50);
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_grant: got %b want 01", bus.req_ready); end
      @(posedge clock50); #1 bus.req_valid = 2'b00;
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clock50);
         if (k <= SETUP) want = 5'b10000;
         else if (k <= SETUP + STROBE) want = 5'b10001;
         else want = 5'b10000;
         checks++; if (sigOut !== want) begin errors++; $display("[TB] FAIL single_sig t+%0d: got %b want %b", k, sigOut, want); end
         checks++; if (done !== (k == FRAME)) begin errors++; $display("[TB] FAIL single_done t+%0d: got %b want %b", k, done, (k == FRAME)); end
         checks++; if (busy !== (k != FRAME)) begin errors++; $display("[TB] FAIL single_busy t+%0d: got %b want %b", k, busy, (k != FRAME)); end
      end
   endtask

   task automatic test_round_robin();
      int order[$];
      int budget;
      pulseReset();
      bus.req_cmd0  = CMD_SEARCH;
      bus.req_cmd1  = CMD_PLACE;
      bus.req_valid = 2'b11;
      budget = 3 * FRAME + 4;
      while (order.size() < 3 && budget > 0) begin
         @(negedge clock50);
         budget--;
         checks++; if (sigOut !== expSig()) begin errors++; $display("[TB] FAIL rr_sig: got %b want %b", sigOut, expSig()); end
         if (bus.req_ready != 2'b00) begin
            checks++; if (bus.req_ready == 2'b11) begin errors++; $display("[TB] FAIL rr_onehot: got %b want one bit", bus.req_ready); end
            if (order.size() > 0) begin
               checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rr_grant_on_done: got done=%b want 1", done); end
            end
            order.push_back(bus.req_ready[1] ? 1 : 0);
         end
      end
      checks++;
      if (order.size() != 3) begin
         errors++; $display("[TB] FAIL rr_count: got %0d grants want 3", order.size());
      end else if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
         errors++; $display("[TB] FAIL rr_order: got %0d%0d%0d want 010", order[0], order[1], order[2]);
      end
      @(posedge clock50); #1 bus.req_valid = 2'b00;
   endtask

   task automatic test_abort();
      int doneCount;
      int readyCount;
      int budget;
      bit found;
      pulseReset();
      bus.req_cmd0  = CMD_PLACE;
      bus.req_valid = 2'b01;
      @(negedge clock50);
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL abort_grant: got %b want 01", bus.req_ready); end
      @(posedge clock50); #1 bus.req_valid = 2'b00;
      found  = 1'b0;
      budget = SETUP + 3;
      while (!found && budget > 0) begin
         @(negedge clock50);
         budget--;
         if (sigOut === 5'b01001) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("[TB] FAIL abort_reach_strobe: got %b want 01001", sigOut); end
      @(posedge clock50); #1 bus.abort_stop = 1'b1;
      @(posedge clock50); #1 bus.abort_stop = 1'b0;
      doneCount  = 0;
      readyCount = 0;
      for (int k = 1; k <= FRAME + 2; k++) begin
         @(negedge clock50);
         if (k == 1) begin
            checks++; if (sigOut !== 5'b00010) begin errors++; $display("[TB] FAIL abort_latency: got %b want 00010", sigOut); end
         end
         checks++; if (sigOut !== expSig()) begin errors++; $display("[TB] FAIL abort_sig k=%0d: got %b want %b", k, sigOut, expSig()); end
         if (done === 1'b1) doneCount++;
         if (bus.req_ready !== 2'b00) readyCount++;
      end
      checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL abort_done_count: got %0d want 1", doneCount); end
      checks++; if (readyCount != 0) begin errors++; $display("[TB] FAIL abort_reack: got %0d ready pulses want 0", readyCount); end
   endtask

   task automatic test_async_reset();
      pulseReset();
      bus.req_cmd0  = CMD_SEARCH;
      bus.req_valid = 2'b01;
      @(negedge clock50);
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL async_grant: got %b want 01", bus.req_ready); end
      repeat (SETUP + 1) @(negedge clock50);
      checks++; if (sigOut !== 5'b10001) begin errors++; $display("[TB] FAIL async_strobe: got %b want 10001", sigOut); end
      #2 resetn = 1'b0;
      #1;
      checks++; if (sigOut !== 5'b00100) begin errors++; $display("[TB] FAIL async_sig: got %b want 00100", sigOut); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %b want 0", busy); end
      @(posedge clock50); #1 resetn = 1'b1;
      @(negedge clock50);
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL async_regrant: got %b want 01", bus.req_ready); end
      @(posedge clock50); #1 bus.req_valid = 2'b00;
      @(negedge clock50);
      checks++; if (sigOut !== 5'b10000) begin errors++; $display("[TB] FAIL async_new_frame: got %b want 10000", sigOut); end
   endtask

   task automatic test_pending();
      pulseReset();
      bus.req_cmd0  = CMD_SEARCH;
      bus.req_valid = 2'b01;
      @(negedge clock50);
      checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL pend_first: got %b want 01", bus.req_ready); end
      @(posedge clock50); #1;
      bus.req_valid = 2'b10;
      bus.req_cmd1  = CMD_PLACE;
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clock50);
         if (k < FRAME) begin
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL pend_hold t+%0d: got %b want 00", k, bus.req_ready); end
         end else begin
            checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL pend_grant: got %b want 10", bus.req_ready); end
         end
      end
      @(posedge clock50); #1;
      bus.req_valid = 2'b00;
      bus.req_cmd1  = CMD_RESET_POS;
      @(negedge clock50);
      checks++; if (sigOut !== 5'b01000) begin errors++; $display("[TB] FAIL pend_latched: got %b want 01000", sigOut); end
   endtask

   task automatic test_random();
      logic [1:0] seenReady;
      pulseReset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clock50);
         checks++; if (sigOut !== expSig()) begin errors++; $display("[TB] FAIL rnd_sig c=%0d: got %b want %b", c, sigOut, expSig()); end
         checks++; if (busy !== expBusy()) begin errors++; $display("[TB] FAIL rnd_busy c=%0d: got %b want %b", c, busy, expBusy()); end
         checks++; if (done !== expDone()) begin errors++; $display("[TB] FAIL rnd_done c=%0d: got %b want %b", c, done, expDone()); end
         checks++; if (bus.req_ready !== expReady()) begin errors++; $display("[TB] FAIL rnd_ready c=%0d: got %b want %b", c, bus.req_ready, expReady()); end
         seenReady = bus.req_ready;
         @(posedge clock50); #1;
         if (seenReady[0] || !bus.req_valid[0]) begin
            bus.req_valid[0] = ($urandom_range(0, 3) == 0);
            bus.req_cmd0     = cmd_t'($urandom_range(0, 3));
         end
         if (seenReady[1] || !bus.req_valid[1]) begin
            bus.req_valid[1] = ($urandom_range(0, 3) == 0);
            bus.req_cmd1     = cmd_t'($urandom_range(0, 3));
         end
         bus.abort_stop = ($urandom_range(0, 24) == 0);
      end
      bus.req_valid  = 2'b00;
      bus.abort_stop = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_single_command();
      test_round_robin();
      test_abort();
      test_async_reset();
      test_pending();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
